// File: rtl/ram_dump_pingpong.sv
// Packs a byte stream into RAM words and writes fixed-length frames into a
// two-bank ping-pong IPbus RAM, with a per-bank FPGA/PC handshake bit pair.
module ram_dump_pingpong #(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 8,
  parameter int FRAME_WORDS    = 256,
  parameter int CNT_W          = 16
) (
  input  logic                             SYSCLK,
  input  logic                             reset,
  input  logic                             dumpMem,
  input  logic                             write_En_datachannel,
  input  logic [DATA_W-1:0]                data_datachannel,
  input  logic [1:0]                       handshakePC,
  output logic [1:0]                       handshakeFPGA,
  output logic [DATA_W*BYTES_PER_WORD-1:0] IPbus_RAM_data,
  output logic [ADDR_W:0]                  IPbus_RAM_address,
  output logic                             IPbus_RAM_we,
  output logic                             dumpdone,
  output logic                             busy,
  output logic                             wr_bank,
  output logic [CNT_W-1:0]                 dropped_frames
);

  localparam int WORD_W = DATA_W * BYTES_PER_WORD;
  localparam int SH_W   = WORD_W - DATA_W;
  localparam int BC_W   = $clog2(BYTES_PER_WORD);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DUMPING,
    TRASH,
    STOPDUMP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          hs_fpga_q, hs_fpga_d;
  logic                wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]    dropped_q, dropped_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [WORD_W-1:0]   packed_word;

  // Earlier beats sit in shift_q, so the current beat completes the word in the LSBs.
  assign packed_word = {shift_q, data_datachannel};

  always_comb begin
    state_d    = state_q;
    hs_fpga_d  = hs_fpga_q;
    wr_bank_d  = wr_bank_q;
    dropped_d  = dropped_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;

    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        word_cnt_d = '0;
        if (dumpMem) begin
          if (hs_fpga_q[wr_bank_q] == handshakePC[wr_bank_q]) begin
            state_d = DUMPING;
          end else begin
            state_d = TRASH;
            if (dropped_q != {CNT_W{1'b1}}) begin
              dropped_d = dropped_q + CNT_W'(1);
            end
          end
        end
      end

      DUMPING, TRASH: begin
        if (write_En_datachannel) begin
          shift_d = packed_word[SH_W-1:0];
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + ADDR_W'(1);
            if (state_q == DUMPING) begin
              we_d   = 1'b1;
              data_d = packed_word;
              addr_d = {wr_bank_q, word_cnt_q};
            end
            // Last word of the frame: hand the bank to the PC only if it was written.
            if (word_cnt_q == LAST_WORD) begin
              state_d    = STOPDUMP;
              done_d     = 1'b1;
              word_cnt_d = '0;
              if (state_q == DUMPING) begin
                hs_fpga_d[wr_bank_q] = ~hs_fpga_q[wr_bank_q];
                wr_bank_d            = ~wr_bank_q;
              end
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end
      end

      STOPDUMP: begin
        state_d    = IDLE;
        byte_cnt_d = '0;
        word_cnt_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hs_fpga_q  <= 2'b00;
      wr_bank_q  <= 1'b0;
      dropped_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      hs_fpga_q  <= hs_fpga_d;
      wr_bank_q  <= wr_bank_d;
      dropped_q  <= dropped_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
    end
  end

  assign handshakeFPGA     = hs_fpga_q;
  assign IPbus_RAM_data    = data_q;
  assign IPbus_RAM_address = addr_q;
  assign IPbus_RAM_we      = we_q;
  assign dumpdone          = done_q;
  assign busy              = (state_q != IDLE);
  assign wr_bank           = wr_bank_q;
  assign dropped_frames    = dropped_q;

endmodule

// File: tb/tb_ram_dump_pingpong.sv
// Scoreboard bench for ram_dump_pingpong: default, small-frame and
// small-counter instances share one clock and are exercised in turn.
module tb_ram_dump_pingpong;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_s_t;

  logic SYSCLK = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;

  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  // Default instance
  logic        dump_mem = 1'b0, we_en = 1'b0;
  logic [7:0]  din = '0;
  logic [1:0]  pc = 2'b00;
  logic [1:0]  hs;
  logic [31:0] ram_data;
  logic [8:0]  ram_addr;
  logic        ram_we, done, busy, bank;
  logic [15:0] dropped;

  ram_dump_pingpong dut (
    .SYSCLK(SYSCLK), .reset(reset), .dumpMem(dump_mem),
    .write_En_datachannel(we_en), .data_datachannel(din),
    .handshakePC(pc), .handshakeFPGA(hs), .IPbus_RAM_data(ram_data),
    .IPbus_RAM_address(ram_addr), .IPbus_RAM_we(ram_we), .dumpdone(done),
    .busy(busy), .wr_bank(bank), .dropped_frames(dropped)
  );

  // Small-frame instance: 2 bytes per word, 4 words per frame
  logic        dump_mem_s = 1'b0, we_en_s = 1'b0;
  logic [7:0]  din_s = '0;
  logic [1:0]  pc_s = 2'b00;
  logic [1:0]  hs_s;
  logic [15:0] ram_data_s;
  logic [2:0]  ram_addr_s;
  logic        ram_we_s, done_s, busy_s, bank_s;
  logic [15:0] dropped_s;

  ram_dump_pingpong #(.DATA_W(8), .BYTES_PER_WORD(2), .ADDR_W(2), .FRAME_WORDS(4), .CNT_W(16)) dut_s (
    .SYSCLK(SYSCLK), .reset(reset), .dumpMem(dump_mem_s),
    .write_En_datachannel(we_en_s), .data_datachannel(din_s),
    .handshakePC(pc_s), .handshakeFPGA(hs_s), .IPbus_RAM_data(ram_data_s),
    .IPbus_RAM_address(ram_addr_s), .IPbus_RAM_we(ram_we_s), .dumpdone(done_s),
    .busy(busy_s), .wr_bank(bank_s), .dropped_frames(dropped_s)
  );

  // Saturation instance: 2-bit dropped counter, bank 0 never free
  logic        dump_mem_c = 1'b0, we_en_c = 1'b0;
  logic [7:0]  din_c = '0;
  logic [1:0]  pc_c = 2'b01;
  logic [1:0]  hs_c;
  logic [15:0] ram_data_c;
  logic [1:0]  ram_addr_c;
  logic        ram_we_c, done_c, busy_c, bank_c;
  logic [1:0]  dropped_c;

  ram_dump_pingpong #(.DATA_W(8), .BYTES_PER_WORD(2), .ADDR_W(1), .FRAME_WORDS(2), .CNT_W(2)) dut_c (
    .SYSCLK(SYSCLK), .reset(reset), .dumpMem(dump_mem_c),
    .write_En_datachannel(we_en_c), .data_datachannel(din_c),
    .handshakePC(pc_c), .handshakeFPGA(hs_c), .IPbus_RAM_data(ram_data_c),
    .IPbus_RAM_address(ram_addr_c), .IPbus_RAM_we(ram_we_c), .dumpdone(done_c),
    .busy(busy_c), .wr_bank(bank_c), .dropped_frames(dropped_c)
  );

  wr_t   exp_q[$];
  wr_s_t exp_s_q[$];
  wr_t   mon_e;
  wr_s_t mon_s_e;
  int    done_cnt = 0, done_cyc = 0;
  int    done_cnt_s = 0, done_cyc_s = 0;
  int    done_cnt_c = 0;

  // Write monitors: every strobe is popped against the scoreboard
  always @(negedge SYSCLK) begin
    if (ram_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write addr=%h data=%h cyc=%0d", ram_addr, ram_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_addr !== mon_e.addr || ram_data !== mon_e.data || cyc !== mon_e.cyc) begin
          fails++;
          $display("[TB] FAIL write got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   ram_addr, ram_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ram_we_s === 1'b1) begin
      tests++;
      if (exp_s_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write_s addr=%h data=%h cyc=%0d", ram_addr_s, ram_data_s, cyc);
      end else begin
        mon_s_e = exp_s_q.pop_front();
        if (ram_addr_s !== mon_s_e.addr || ram_data_s !== mon_s_e.data || cyc !== mon_s_e.cyc) begin
          fails++;
          $display("[TB] FAIL write_s got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   ram_addr_s, ram_data_s, cyc, mon_s_e.addr, mon_s_e.data, mon_s_e.cyc);
        end
      end
    end
    if (done_s === 1'b1) begin
      done_cnt_s++;
      done_cyc_s = cyc;
    end
    if (ram_we_c === 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL unexpected_write_c addr=%h data=%h", ram_addr_c, ram_data_c);
    end
    if (done_c === 1'b1) done_cnt_c++;
  end

  task automatic drive_frame(input int n_beats, input bit expect_wr, input bit wbank);
    logic [31:0] w = '0;
    @(negedge SYSCLK);
    dump_mem = 1'b1;
    for (int k = 0; k < n_beats; k++) begin
      @(negedge SYSCLK);
      dump_mem = 1'b0;
      we_en    = 1'b1;
      din      = 8'(k);
      w        = {w[23:0], din};
      if (expect_wr && (k % 4 == 3)) exp_q.push_back('{addr: {wbank, 8'(k / 4)}, data: w, cyc: cyc + 1});
    end
  endtask

  task automatic check_frame_end(input string name, input int done0, input logic [1:0] exp_hs,
                                 input logic exp_bank, input logic [15:0] exp_drop);
    @(negedge SYSCLK);
    we_en = 1'b0;
    repeat (4) @(negedge SYSCLK);
    tests++;
    if (done_cnt - done0 !== 1 || hs !== exp_hs || bank !== exp_bank || dropped !== exp_drop ||
        busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s got done=%0d hs=%b bank=%b drop=%0d busy=%b pending=%0d expected done=1 hs=%b bank=%b drop=%0d busy=0 pending=0",
               name, done_cnt - done0, hs, bank, dropped, busy, exp_q.size(), exp_hs, exp_bank, exp_drop);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge SYSCLK);
    tests++;
    if (hs !== 2'b00 || bank !== 1'b0 || dropped !== '0 || ram_we !== 1'b0 || ram_addr !== '0 ||
        ram_data !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state hs=%b bank=%b drop=%0d we=%b addr=%h data=%h done=%b busy=%b expected all zero",
               hs, bank, dropped, ram_we, ram_addr, ram_data, done, busy);
    end
    reset = 1'b0;
    @(negedge SYSCLK);
  endtask

  task automatic test_pingpong;
    int d0;
    d0 = done_cnt;
    drive_frame(1024, 1'b1, 1'b0);
    check_frame_end("frame1_bank0", d0, 2'b01, 1'b1, 16'd0);
    d0 = done_cnt;
    drive_frame(1024, 1'b1, 1'b1);
    check_frame_end("frame2_bank1", d0, 2'b11, 1'b0, 16'd0);
  endtask

  task automatic test_trash;
    int d0;
    d0 = done_cnt;
    drive_frame(1024, 1'b0, 1'b0);
    check_frame_end("frame3_trash", d0, 2'b11, 1'b0, 16'd1);
    pc = 2'b01;
    d0 = done_cnt;
    drive_frame(1024, 1'b1, 1'b0);
    check_frame_end("frame4_bank0", d0, 2'b10, 1'b1, 16'd1);
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] w = '0;
    pc = 2'b11;
    @(negedge SYSCLK);
    dump_mem = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge SYSCLK);
      dump_mem = 1'b0;
      we_en    = 1'b1;
      din      = 8'(k);
      w        = {w[23:0], din};
      if ((k % 4 == 3) && (k / 4 < 124)) exp_q.push_back('{addr: {1'b1, 8'(k / 4)}, data: w, cyc: cyc + 1});
    end
    @(posedge SYSCLK);
    #1;
    we_en = 1'b0;
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 9'h17C || ram_data !== 32'hF0F1F2F3) begin
      fails++;
      $display("[TB] FAIL pre_reset_write we=%b addr=%h data=%h expected we=1 addr=17c data=f0f1f2f3",
               ram_we, ram_addr, ram_data);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (ram_we !== 1'b0 || hs !== 2'b00 || bank !== 1'b0 || dropped !== '0 || busy !== 1'b0 ||
        ram_addr !== '0 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL reset_mid_frame we=%b hs=%b bank=%b drop=%0d busy=%b addr=%h pending=%0d expected zeros",
               ram_we, hs, bank, dropped, busy, ram_addr, exp_q.size());
    end
    @(negedge SYSCLK);
    reset = 1'b0;
    pc    = 2'b00;
    drive_frame(1024, 1'b1, 1'b0);
    check_frame_end("frame_after_reset", done_cnt, 2'b01, 1'b1, 16'd0);
  endtask

  task automatic test_gated_small;
    logic [15:0] w = '0;
    int last_cyc = 0;
    int d0;
    for (int k = 0; k < 6; k++) begin
      @(negedge SYSCLK);
      we_en_s = 1'b1;
      din_s   = 8'(8'h55 + k);
    end
    @(negedge SYSCLK);
    we_en_s    = 1'b0;
    dump_mem_s = 1'b1;
    d0 = done_cnt_s;
    for (int k = 0; k < 8; k++) begin
      @(negedge SYSCLK);
      dump_mem_s = 1'b0;
      we_en_s    = 1'b1;
      din_s      = 8'(160 + k);
      w          = {w[7:0], din_s};
      last_cyc   = cyc;
      if (k % 2 == 1) exp_s_q.push_back('{addr: {1'b0, 2'(k / 2)}, data: w, cyc: cyc + 1});
      @(negedge SYSCLK);
      we_en_s = 1'b0;
    end
    repeat (4) @(negedge SYSCLK);
    tests++;
    if (done_cnt_s - d0 !== 1 || done_cyc_s !== last_cyc + 1 || hs_s !== 2'b01 || bank_s !== 1'b1 ||
        exp_s_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL gated_small got done=%0d done_cyc=%0d hs=%b bank=%b pending=%0d expected done=1 done_cyc=%0d hs=01 bank=1 pending=0",
               done_cnt_s - d0, done_cyc_s, hs_s, bank_s, exp_s_q.size(), last_cyc + 1);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_drop;
    for (int f = 1; f <= 5; f++) begin
      @(negedge SYSCLK);
      dump_mem_c = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge SYSCLK);
        dump_mem_c = 1'b0;
        we_en_c    = 1'b1;
        din_c      = 8'(k);
      end
      @(negedge SYSCLK);
      we_en_c = 1'b0;
      repeat (3) @(negedge SYSCLK);
      exp_drop = (f >= 3) ? 2'd3 : 2'(f);
      tests++;
      if (dropped_c !== exp_drop || done_cnt_c !== f || hs_c !== 2'b00 || bank_c !== 1'b0) begin
        fails++;
        $display("[TB] FAIL saturate_frame%0d got drop=%0d done=%0d hs=%b bank=%b expected drop=%0d done=%0d hs=00 bank=0",
                 f, dropped_c, done_cnt_c, hs_c, bank_c, exp_drop, f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pingpong();
    test_trash();
    test_reset_mid_frame();
    test_gated_small();
    test_saturation();
    repeat (3) @(negedge SYSCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_dump_pingpong.md
Name: ram_dump_pingpong

Overview:
- Parametrised successor to the single-buffer frame dump manager.
- Packs the byte stream from the data channel into RAM words of configurable width and writes frames of configurable length into a two-bank (ping-pong) IPbus RAM.
- Each bank has its own FPGA/PC handshake pair, so the PC can read one bank while the next frame fills the other.
- Frames that find no free bank are consumed at full length with no RAM writes and are counted.

Parameters:
- DATA_W, 8: width of data_datachannel.
- BYTES_PER_WORD, 4: input beats packed into one RAM word, >=2.
- ADDR_W, 8: word-address width per bank.
- FRAME_WORDS, 256: words per frame, 1..2**ADDR_W.
- CNT_W, 16: width of the dropped-frame counter.

Ports:
- SYSCLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dumpMem  in  1  frame start request, sampled in IDLE only.
- write_En_datachannel  in  1  input beat valid.
- data_datachannel  in  DATA_W  input beat.
- handshakePC  in  2  PC handshake bit per bank.
- handshakeFPGA  out  2  FPGA handshake bit per bank.
- IPbus_RAM_data  out  DATA_W*BYTES_PER_WORD  packed word; first beat in MSBs.
- IPbus_RAM_address  out  ADDR_W+1  {bank, word index}.
- IPbus_RAM_we  out  1  RAM write strobe.
- dumpdone  out  1  one-cycle end-of-frame pulse.
- busy  out  1  high in any state except IDLE.
- wr_bank  out  1  bank targeted by the next or current frame.
- dropped_frames  out  CNT_W  saturating count of trashed frames.

Behaviour:
- Reset values (all outputs and internal registers):
  - state=IDLE; handshakeFPGA=2'b00; wr_bank=0; dropped_frames=0.
  - Address, data, IPbus_RAM_we, dumpdone, byte counter and word counter all 0.
- States: IDLE, DUMPING, TRASH, STOPDUMP.
- IDLE:
  - dumpMem=1 and handshakeFPGA[wr_bank]==handshakePC[wr_bank] -> DUMPING.
  - dumpMem=1 and the bits differ -> TRASH, with dropped_frames +1 (saturates at all-ones).
  - Beats arriving in IDLE are ignored; byte and word counters are held at 0.
- Packing (DUMPING and TRASH):
  - Each write_En_datachannel beat shifts data into the word register, first beat ending up in the MSBs, and increments byte_cnt.
  - On the beat with byte_cnt==BYTES_PER_WORD-1: byte_cnt wraps to 0 and a word is complete.
  - In DUMPING only: the next cycle asserts IPbus_RAM_we for exactly 1 cycle, with IPbus_RAM_data=packed word and address={wr_bank, word_cnt}.
  - word_cnt increments in the same cycle as the write strobe. In TRASH it increments with we held low.
  - Latency: last beat of a word to we is 1 cycle.
  - Back-to-back beats are supported: a new word fills while the previous write is strobed.
- Frame end:
  - The word completing with word_cnt==FRAME_WORDS-1 moves the FSM to STOPDUMP on the cycle its strobe (or the TRASH equivalent) is issued.
  - STOPDUMP lasts 1 cycle: dumpdone=1, then IDLE.
  - Beats arriving during STOPDUMP are ignored.
- Handshake:
  - On DUMPING->STOPDUMP: handshakeFPGA[wr_bank] toggles and wr_bank toggles, both in the same cycle.
  - TRASH->STOPDUMP changes neither.
  - A bank is free for writing when its FPGA and PC bits are equal.
- dumpMem outside IDLE is ignored.
- handshakePC is assumed synchronous to SYSCLK; synchronising it is done upstream.
- Reset mid-frame:
  - Frame is aborted immediately; all state returns to the reset values.
  - Partial words are discarded; no further writes are issued.
- Address output is held at the last written value when we=0.

Test Plan:
- Defaults, handshakePC=00, dumpMem pulse then 1024 consecutive beats 0x00..0xFF repeating:
  - 256 writes to addresses 0x000..0x0FF.
  - Word 0 data=0x00010203; each write one cycle after its 4th beat.
  - dumpdone pulses once; handshakeFPGA=01; wr_bank=1.
- Second frame with handshakePC still 00:
  - Writes go to 0x100..0x1FF; handshakeFPGA=11; wr_bank=0.
- Third frame with handshakePC still 00 (bank 0 busy):
  - No we across 1024 beats; dumpdone pulses; dropped_frames=1; handshakeFPGA stays 11.
  - Set handshakePC=01, fourth frame -> writes to 0x000..; handshakeFPGA=10.
- Beats gated every other cycle, FRAME_WORDS=4, BYTES_PER_WORD=2:
  - Exactly 4 writes with correct 16-bit packing; dumpdone 1 cycle after the 8th beat.
  - Beats sent in IDLE beforehand produce no writes.
- Reset asserted after 500 beats of a frame:
  - we drops in the same cycle; handshakeFPGA=00; wr_bank=0; counters 0.
  - A following frame writes from address 0x000.
- CNT_W=2, five trashed frames -> dropped_frames saturates at 3.
